// File: rtl/loteria_pkg.sv
// Shared types and helpers for the multi-player lottery block.
// State encoding, prize codes and the match-count to prize mapping.
package loteria_pkg;

  typedef enum logic [1:0] {
    ST_BET  = 2'd0,
    ST_DRAW = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] PRZ_NONE = 2'd0;
  localparam logic [1:0] PRZ_LOW  = 2'd1;
  localparam logic [1:0] PRZ_MID  = 2'd2;
  localparam logic [1:0] PRZ_TOP  = 2'd3;

  function automatic logic [1:0] prize_of(
    input logic [3:0] m,
    input int         picks
  );
    if (int'(m) == picks)
      return PRZ_TOP;
    else if (int'(m) == picks - 1)
      return PRZ_MID;
    else if (int'(m) == picks - 2)
      return PRZ_LOW;
    else
      return PRZ_NONE;
  endfunction

endpackage

// File: rtl/loteria_match.sv
// Counts how many entries of one ticket appear anywhere in the draw.
// Purely combinational; shared across players by the parent.
module loteria_match
  import loteria_pkg::*;
#(
  parameter int NUM_W = 4,
  parameter int PICKS = 4
) (
  input  logic [PICKS*NUM_W-1:0] ticket,
  input  logic [PICKS*NUM_W-1:0] draw,
  output logic [3:0]             m
);

  logic hit;

  always_comb begin
    m   = '0;
    hit = 1'b0;
    for (int i = 0; i < PICKS; i++) begin
      hit = 1'b0;
      for (int j = 0; j < PICKS; j++) begin
        if (ticket[i*NUM_W +: NUM_W] == draw[j*NUM_W +: NUM_W])
          hit = 1'b1;
      end
      m = m + {3'b000, hit};
    end
  end

endmodule

// File: rtl/loteria_multi.sv
// Multi-player lottery: ticket entry, draw entry, per-player scoring.
// One match unit is time-shared, one player per EVAL cycle.
module loteria_multi
  import loteria_pkg::*;
#(
  parameter int NUM_W   = 4,
  parameter int PICKS   = 4,
  parameter int PLAYERS = 2,
  parameter int SCORE_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_W-1:0]           numero,
  input  logic                       insere,
  input  logic                       fim,
  input  logic                       fim_jogo,
  output logic [2*PLAYERS-1:0]       premio,
  output logic [SCORE_W*PLAYERS-1:0] pontos,
  output logic [1:0]                 estado,
  output logic [2:0]                 jogador,
  output logic                       pronto,
  output logic                       dup_err,
  output logic                       result_valid
);

  localparam int TW = PICKS * NUM_W;

  state_t state, state_nx;

  logic [TW-1:0]              tick_q [PLAYERS];
  logic [TW-1:0]              draw_q;
  logic [2:0]                 idx;
  logic [2:0]                 jog;
  logic [2:0]                 ecnt;
  logic [2*PLAYERS-1:0]       premio_q;
  logic [SCORE_W*PLAYERS-1:0] pontos_q;
  logic                       dup_q;

  logic [TW-1:0]      cur;
  logic [TW-1:0]      eval_tk;
  logic [SCORE_W-1:0] cur_pts;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] new_pts;
  logic [3:0]         m;
  logic [1:0]         prz;
  logic               dup;
  logic               acc;
  logic               rej;
  logic               clr;
  logic               last_pick;

  loteria_match #(
    .NUM_W (NUM_W),
    .PICKS (PICKS)
  ) u_match (
    .ticket (eval_tk),
    .draw   (draw_q),
    .m      (m)
  );

  assign pronto    = (state == ST_BET) || (state == ST_DRAW);
  assign clr       = fim || (fim_jogo && state != ST_EVAL);
  assign last_pick = (idx == 3'(PICKS - 1));
  assign acc       = insere && pronto && !dup && !clr;
  assign rej       = insere && pronto && dup && !clr;
  assign prz       = prize_of(m, PICKS);

  // Only entries below idx are live; cleared slots must not match.
  always_comb begin
    cur = draw_q;
    if (state == ST_BET) begin
      cur = '0;
      for (int p = 0; p < PLAYERS; p++)
        if (jog == 3'(p)) cur = tick_q[p];
    end
    dup = 1'b0;
    for (int j = 0; j < PICKS; j++)
      if (3'(j) < idx && cur[j*NUM_W +: NUM_W] == numero)
        dup = 1'b1;
  end

  always_comb begin
    eval_tk = '0;
    cur_pts = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (ecnt == 3'(p)) begin
        eval_tk = tick_q[p];
        cur_pts = pontos_q[p*SCORE_W +: SCORE_W];
      end
    end
    sum     = {1'b0, cur_pts} + (SCORE_W+1)'(prz);
    new_pts = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = ST_BET;
    end else begin
      unique case (state)
        ST_BET:
          if (acc && last_pick && jog == 3'(PLAYERS - 1))
            state_nx = ST_DRAW;
        ST_DRAW:
          if (acc && last_pick) state_nx = ST_EVAL;
        ST_EVAL:
          if (ecnt == 3'(PLAYERS - 1)) state_nx = ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_BET;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < PLAYERS; p++) tick_q[p] <= '0;
      draw_q   <= '0;
      idx      <= '0;
      jog      <= '0;
      ecnt     <= '0;
      premio_q <= '0;
      pontos_q <= '0;
      dup_q    <= 1'b0;
    end else begin
      dup_q <= rej;
      if (clr) begin
        for (int p = 0; p < PLAYERS; p++) tick_q[p] <= '0;
        draw_q   <= '0;
        idx      <= '0;
        jog      <= '0;
        ecnt     <= '0;
        premio_q <= '0;
        if (fim) pontos_q <= '0;
      end else begin
        unique case (state)
          ST_BET: begin
            if (acc) begin
              for (int p = 0; p < PLAYERS; p++)
                for (int j = 0; j < PICKS; j++)
                  if (jog == 3'(p) && idx == 3'(j))
                    tick_q[p][j*NUM_W +: NUM_W] <= numero;
              if (last_pick) begin
                idx <= '0;
                jog <= jog + 3'd1;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end
          ST_DRAW: begin
            if (acc) begin
              for (int j = 0; j < PICKS; j++)
                if (idx == 3'(j))
                  draw_q[j*NUM_W +: NUM_W] <= numero;
              idx <= last_pick ? 3'd0 : idx + 3'd1;
            end
          end
          ST_EVAL: begin
            for (int p = 0; p < PLAYERS; p++) begin
              if (ecnt == 3'(p)) begin
                premio_q[2*p +: 2]             <= prz;
                pontos_q[p*SCORE_W +: SCORE_W] <= new_pts;
              end
            end
            ecnt <= (ecnt == 3'(PLAYERS - 1)) ? 3'd0 : ecnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign premio       = premio_q;
  assign pontos       = pontos_q;
  assign estado       = state;
  assign jogador      = jog;
  assign dup_err      = dup_q;
  assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_loteria_multi.sv
// Directed bench for loteria_multi with 2-bit scores and two players.
// Expected values are hand-derived from the round scenarios.
module tb_loteria_multi;

  logic       clock;
  logic       reset;
  logic [3:0] numero;
  logic       insere;
  logic       fim;
  logic       fim_jogo;
  logic [3:0] premio;
  logic [3:0] pontos;
  logic [1:0] estado;
  logic [2:0] jogador;
  logic       pronto;
  logic       dup_err;
  logic       result_valid;

  int errors = 0;
  int checks = 0;

  loteria_multi #(
    .NUM_W   (4),
    .PICKS   (4),
    .PLAYERS (2),
    .SCORE_W (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .numero       (numero),
    .insere       (insere),
    .fim          (fim),
    .fim_jogo     (fim_jogo),
    .premio       (premio),
    .pontos       (pontos),
    .estado       (estado),
    .jogador      (jogador),
    .pronto       (pronto),
    .dup_err      (dup_err),
    .result_valid (result_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [3:0] n);
    numero = n;
    insere = 1'b1;
    step();
    insere = 1'b0;
  endtask

  task automatic put4(input logic [3:0] a, b, c, d);
    put(a);
    put(b);
    put(c);
    put(d);
  endtask

  initial begin
    reset    = 1'b0;
    numero   = '0;
    insere   = 1'b0;
    fim      = 1'b0;
    fim_jogo = 1'b0;
    #3;
    check("rst_estado", 32'(estado), 0);
    check("rst_pronto", 32'(pronto), 1);
    check("rst_premio", 32'(premio), 0);
    check("rst_pontos", 32'(pontos), 0);
    check("rst_dup", 32'(dup_err), 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_jog", 32'(jogador), 0);
    reset = 1'b1;
    step();

    // round 1: P1 hits the jackpot
    put4(0, 1, 2, 3);
    check("r1_jog1", 32'(jogador), 1);
    check("r1_bet", 32'(estado), 0);
    put4(5, 6, 7, 8);
    check("r1_draw", 32'(estado), 1);
    put4(5, 6, 7, 8);
    check("r1_eval", 32'(estado), 2);
    check("r1_pronto0", 32'(pronto), 0);
    step();
    check("r1_eval2", 32'(estado), 2);
    check("r1_rv0", 32'(result_valid), 0);
    step();
    check("r1_done", 32'(estado), 3);
    check("r1_rv1", 32'(result_valid), 1);
    check("r1_premio", 32'(premio), 32'hC);
    check("r1_pontos", 32'(pontos), 32'hC);
    put(9);
    check("r1_done_ign", 32'(estado), 3);
    check("r1_done_dup", 32'(dup_err), 0);

    fim_jogo = 1'b1;
    step();
    fim_jogo = 1'b0;
    check("nr_estado", 32'(estado), 0);
    check("nr_premio", 32'(premio), 0);
    check("nr_pontos", 32'(pontos), 32'hC);
    check("nr_rv", 32'(result_valid), 0);

    // round 2: P0 gets 3 of 4, P1 jackpot saturates at 3
    put4(5, 6, 7, 1);
    put4(5, 6, 7, 8);
    put4(5, 6, 7, 8);
    step();
    step();
    check("r2_done", 32'(estado), 3);
    check("r2_premio", 32'(premio), 32'hE);
    check("r2_pontos", 32'(pontos), 32'hE);

    fim_jogo = 1'b1;
    step();
    fim_jogo = 1'b0;

    // round 3: duplicates, then reset during EVAL
    put(3);
    put(3);
    check("dup_pulse", 32'(dup_err), 1);
    check("dup_jog", 32'(jogador), 0);
    step();
    check("dup_clear", 32'(dup_err), 0);
    put(4);
    put(5);
    check("dup_idx", 32'(jogador), 0);
    put(6);
    check("dup_next", 32'(jogador), 1);
    put(0);
    check("zero_ok", 32'(dup_err), 0);
    put(1);
    put(2);
    put(3);
    check("r3_draw", 32'(estado), 1);
    put(1);
    put(1);
    check("draw_dup", 32'(dup_err), 1);
    check("draw_dup_st", 32'(estado), 1);
    put(2);
    put(3);
    put(4);
    check("r3_eval", 32'(estado), 2);
    check("r3_pts_pre", 32'(pontos), 32'hE);
    reset = 1'b0;
    #1;
    check("rstev_pontos", 32'(pontos), 0);
    check("rstev_estado", 32'(estado), 0);
    check("rstev_premio", 32'(premio), 0);
    check("rstev_pronto", 32'(pronto), 1);
    check("rstev_jog", 32'(jogador), 0);
    reset = 1'b1;
    step();

    // round 4: prize codes 3 and 1, fim_jogo in EVAL ignored
    put4(1, 2, 3, 4);
    put4(1, 2, 9, 10);
    put4(1, 2, 3, 4);
    fim_jogo = 1'b1;
    step();
    fim_jogo = 1'b0;
    check("r4_eval_keep", 32'(estado), 2);
    step();
    check("r4_done", 32'(estado), 3);
    check("r4_premio", 32'(premio), 32'h7);
    check("r4_pontos", 32'(pontos), 32'h7);

    fim_jogo = 1'b1;
    step();
    fim_jogo = 1'b0;

    // abort in DRAW keeps scores
    put4(0, 1, 2, 3);
    put4(4, 5, 6, 7);
    check("ab_draw", 32'(estado), 1);
    put(9);
    fim_jogo = 1'b1;
    step();
    fim_jogo = 1'b0;
    check("ab_estado", 32'(estado), 0);
    check("ab_pontos", 32'(pontos), 32'h7);
    check("ab_jog", 32'(jogador), 0);

    // fim beats insere and clears scores
    numero   = 4'd7;
    insere   = 1'b1;
    fim      = 1'b1;
    step();
    insere   = 1'b0;
    fim      = 1'b0;
    check("fim_pontos", 32'(pontos), 0);
    check("fim_estado", 32'(estado), 0);
    put(7);
    check("fim_nostore", 32'(dup_err), 0);
    put(7);
    check("fim_stored", 32'(dup_err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
